// File: rtl/elevator_request_scheduler.sv
// Single-car elevator request scheduler: collects floor calls into a pending
// bitmap and sweeps up/down (SCAN), holding the door open for a fixed dwell.
module elevator_request_scheduler #(
    parameter int unsigned NUM_FLOORS   = 10,
    parameter int unsigned DWELL_CYCLES = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic [3:0]            req_floor,
    input  logic [3:0]            current_floor,
    input  logic                  car_moving,
    output logic [3:0]            target_floor,
    output logic                  target_valid,
    output logic                  dir_up,
    output logic                  door_open,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  req_err
);
    localparam int unsigned   CW         = $clog2(DWELL_CYCLES + 1);
    localparam logic [CW-1:0] DWELL_LOAD = CW'(DWELL_CYCLES);

    typedef enum logic [1:0] {IDLE, SWEEP_UP, SWEEP_DOWN, DOOR} state_t;

    state_t          state;
    logic [CW-1:0]   dwell_cnt;

    logic                  req_ok, req_bad, req_here, here_pend, at_stop;
    logic [NUM_FLOORS-1:0] set_mask, clr_mask, pending_nxt;
    logic                  up_hit, dn_hit, pick_up, pref_up, go_up, go_dn;
    logic [3:0]            up_floor, dn_floor;
    state_t                disp_state;
    logic                  disp_dir, disp_tv;
    logic [3:0]            disp_tf;

    always_comb begin
        req_ok    = req_valid && (32'(req_floor) < NUM_FLOORS);
        req_bad   = req_valid && !(32'(req_floor) < NUM_FLOORS);
        req_here  = req_ok && (req_floor == current_floor);
        set_mask  = '0;
        clr_mask  = '0;
        here_pend = 1'b0;
        up_hit    = 1'b0;
        up_floor  = '0;
        dn_hit    = 1'b0;
        dn_floor  = '0;
        // Ascending scan: first hit above is the lowest, last hit below is the highest.
        for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
            if (req_ok && req_floor == 4'(i) && !(state == DOOR && req_here))
                set_mask[i] = 1'b1;
            if (current_floor == 4'(i))
                here_pend = pending[i];
            if (pending[i] && 4'(i) > current_floor && !up_hit) begin
                up_hit   = 1'b1;
                up_floor = 4'(i);
            end
            if (pending[i] && 4'(i) < current_floor) begin
                dn_hit   = 1'b1;
                dn_floor = 4'(i);
            end
        end
        at_stop = !car_moving && here_pend && (state != DOOR);
        for (int unsigned i = 0; i < NUM_FLOORS; i++)
            if (at_stop && current_floor == 4'(i))
                clr_mask[i] = 1'b1;
        // Clear after set so an arrival drops a same-cycle request for that floor.
        pending_nxt = (pending | set_mask) & ~clr_mask;

        pick_up = up_hit && (!dn_hit || (up_floor - current_floor) <= (current_floor - dn_floor));
        case (state)
            SWEEP_UP:   pref_up = 1'b1;
            SWEEP_DOWN: pref_up = 1'b0;
            DOOR:       pref_up = dir_up;
            default:    pref_up = pick_up;
        endcase
        if (state == IDLE) begin
            go_up = pick_up;
            go_dn = dn_hit && !pick_up;
        end else begin
            go_up = pref_up ? up_hit : (up_hit && !dn_hit);
            go_dn = pref_up ? (dn_hit && !up_hit) : dn_hit;
        end

        disp_state = IDLE;
        disp_dir   = dir_up;
        disp_tf    = target_floor;
        disp_tv    = 1'b0;
        if (go_up) begin
            disp_state = SWEEP_UP;
            disp_dir   = 1'b1;
            disp_tf    = up_floor;
            disp_tv    = 1'b1;
        end else if (go_dn) begin
            disp_state = SWEEP_DOWN;
            disp_dir   = 1'b0;
            disp_tf    = dn_floor;
            disp_tv    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            pending      <= '0;
            target_floor <= '0;
            target_valid <= 1'b0;
            dir_up       <= 1'b1;
            door_open    <= 1'b0;
            req_err      <= 1'b0;
            dwell_cnt    <= '0;
        end else begin
            pending <= pending_nxt;
            req_err <= req_bad;
            if (state == DOOR) begin
                if (req_here) begin
                    dwell_cnt <= DWELL_LOAD;
                end else if (dwell_cnt <= CW'(1)) begin
                    dwell_cnt    <= '0;
                    door_open    <= 1'b0;
                    state        <= disp_state;
                    dir_up       <= disp_dir;
                    target_floor <= disp_tf;
                    target_valid <= disp_tv;
                end else begin
                    dwell_cnt <= dwell_cnt - CW'(1);
                end
            end else if (at_stop) begin
                state        <= DOOR;
                door_open    <= 1'b1;
                dwell_cnt    <= DWELL_LOAD;
                target_valid <= 1'b0;
            end else if ((state == IDLE && !car_moving) ||
                         (state != IDLE && (go_up || go_dn || pending == '0))) begin
                // IDLE picks a direction only once the car is settled at a floor.
                state        <= disp_state;
                dir_up       <= disp_dir;
                target_floor <= disp_tf;
                target_valid <= disp_tv;
            end
        end
    end
endmodule

// File: tb/tb_elevator_request_scheduler.sv
// Scoreboard bench for elevator_request_scheduler: stimulus queues expected
// target/door/error events, a monitor matches them as the DUT produces them.
module tb_elevator_request_scheduler;
    localparam int unsigned NF = 10;
    localparam int unsigned DW = 8;
    localparam int EV_TGT  = 0;
    localparam int EV_DOOR = 1;
    localparam int EV_ERR  = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic [3:0]    req_floor = '0;
    logic [3:0]    current_floor = '0;
    logic          car_moving = 1'b0;
    logic [3:0]    target_floor;
    logic          target_valid, dir_up, door_open, req_err;
    logic [NF-1:0] pending;

    elevator_request_scheduler #(.NUM_FLOORS(NF), .DWELL_CYCLES(DW)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_floor(req_floor),
        .current_floor(current_floor), .car_moving(car_moving),
        .target_floor(target_floor), .target_valid(target_valid), .dir_up(dir_up),
        .door_open(door_open), .pending(pending), .req_err(req_err)
    );

    always #5 clk = ~clk;

    typedef struct {int kind; int val; int dir;} ev_t;
    ev_t sbq[$];
    int  total_cnt = 0;
    int  pass_cnt  = 0;

    task automatic check(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    task automatic expect_ev(input int k, input int v, input int d);
        ev_t e;
        e.kind = k; e.val = v; e.dir = d;
        sbq.push_back(e);
    endtask

    task automatic report(input int k, input int v, input int d);
        ev_t e;
        if (sbq.size() == 0) begin
            total_cnt++;
            $display("FAIL sb_extra: got event kind %0d value %0d dir %0d, expected none", k, v, d);
        end else begin
            e = sbq.pop_front();
            check("sb_kind", k, e.kind);
            check("sb_value", v, e.val);
            if (e.kind == EV_TGT) check("sb_dir", d, e.dir);
        end
    endtask

    logic       mon_prev_tv = 1'b0;
    logic [3:0] mon_prev_tf = '0;
    int         mon_door_len = 0;
    int         mon_err_len = 0;

    initial begin
        forever begin
            @(posedge clk); #1;
            if (rst) begin
                mon_prev_tv = 1'b0; mon_door_len = 0; mon_err_len = 0;
            end else begin
                if (door_open) mon_door_len++;
                else if (mon_door_len > 0) begin report(EV_DOOR, mon_door_len, 0); mon_door_len = 0; end
                if (req_err) mon_err_len++;
                else if (mon_err_len > 0) begin report(EV_ERR, mon_err_len, 0); mon_err_len = 0; end
                if (target_valid && (!mon_prev_tv || target_floor != mon_prev_tf))
                    report(EV_TGT, int'(target_floor), int'(dir_up));
                mon_prev_tv = target_valid;
                mon_prev_tf = target_floor;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input int f);
        @(negedge clk); req_valid = 1'b1; req_floor = 4'(f);
        @(negedge clk); req_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b1; req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_pending"}, int'(pending), 0);
        check({tag, "_target_floor"}, int'(target_floor), 0);
        check({tag, "_target_valid"}, int'(target_valid), 0);
        check({tag, "_dir_up"}, int'(dir_up), 1);
        check({tag, "_door_open"}, int'(door_open), 0);
        check({tag, "_req_err"}, int'(req_err), 0);
    endtask

    task automatic wait_door(input logic level, input int limit, input string name);
        int n = 0;
        while (door_open !== level && n < limit) begin @(negedge clk); n++; end
        check(name, int'(door_open), int'(level));
    endtask

    // Car leaves 'from', passes intermediate floors, then stops at 'to' in one step.
    task automatic travel(input int from, input int to, input bit arrive_req);
        @(negedge clk); car_moving = 1'b1;
        if (to > from) begin
            for (int f = from + 1; f < to; f++) begin @(negedge clk); current_floor = 4'(f); @(negedge clk); end
        end else begin
            for (int f = from - 1; f > to; f--) begin @(negedge clk); current_floor = 4'(f); @(negedge clk); end
        end
        @(negedge clk); current_floor = 4'(to); car_moving = 1'b0;
        if (arrive_req) begin req_valid = 1'b1; req_floor = 4'(to); end
        @(negedge clk); req_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Single request from floor 0.
        do_reset();
        check_reset("reset");
        expect_ev(EV_TGT, 3, 1);
        send(3);
        check("s1_pending", int'(pending), 'h008);
        check("s1_target_lag", int'(target_valid), 0);
        tick(1);
        check("s1_target_valid", int'(target_valid), 1);
        expect_ev(EV_DOOR, DW, 0);
        travel(0, 3, 1'b0);
        wait_door(1'b0, 20, "s1_door_close");
        check("s1_idle_tv", int'(target_valid), 0);

        // Requests 5 then 2 from floor 0: 2 served first, then 5.
        do_reset();
        expect_ev(EV_TGT, 5, 1);
        expect_ev(EV_TGT, 2, 1);
        send(5);
        send(2);
        expect_ev(EV_DOOR, DW, 0);
        expect_ev(EV_TGT, 5, 1);
        tick(1);
        travel(0, 2, 1'b0);
        check("s2_door_at_2", int'(door_open), 1);
        wait_door(1'b0, 20, "s2_door_close");
        expect_ev(EV_DOOR, DW, 0);
        travel(2, 5, 1'b0);
        wait_door(1'b0, 20, "s2_door_close5");
        check("s2_pending_empty", int'(pending), 0);

        // Sweep up from 4 with 1 and 6 pending; same-cycle request at 6 is dropped.
        do_reset();
        current_floor = 4'd4;
        expect_ev(EV_TGT, 6, 1);
        send(6);
        tick(1);
        send(1);
        expect_ev(EV_DOOR, DW, 0);
        expect_ev(EV_TGT, 1, 0);
        travel(4, 6, 1'b1);
        check("s3_clear_wins", int'(pending), 'h002);
        check("s3_door_at_6", int'(door_open), 1);
        wait_door(1'b0, 20, "s3_door_close");
        check("s3_dir_down", int'(dir_up), 0);
        check("s3_target_1", int'(target_floor), 1);
        expect_ev(EV_DOOR, DW, 0);
        travel(6, 1, 1'b0);
        wait_door(1'b0, 20, "s3_door_close1");
        check("s3_dir_retained", int'(dir_up), 0);
        check("s3_idle_tv", int'(target_valid), 0);

        // Idle at 4 with 2 and 6 pending: equal distance resolves upward.
        car_moving = 1'b1;
        current_floor = 4'd4;
        send(2);
        send(6);
        check("s4_pending", int'(pending), 'h044);
        expect_ev(EV_TGT, 6, 1);
        @(negedge clk); car_moving = 1'b0;
        tick(1);
        check("s4_tie_dir", int'(dir_up), 1);
        check("s4_tie_target", int'(target_floor), 6);

        // Out-of-range requests and the top valid floor.
        do_reset();
        check_reset("reset_mid");
        car_moving = 1'b1;
        current_floor = 4'd0;
        send(NF - 1);
        check("s5_top_floor", int'(pending), 'h200);
        expect_ev(EV_ERR, 1, 0);
        send(12);
        check("s5_err_pulse", int'(req_err), 1);
        tick(1);
        check("s5_err_clear", int'(req_err), 0);
        check("s5_pending_kept", int'(pending), 'h200);
        expect_ev(EV_ERR, 1, 0);
        send(NF);
        check("s5_pending_kept2", int'(pending), 'h200);

        // Door reopen: request for the current floor during dwell restarts it.
        do_reset();
        car_moving = 1'b0;
        current_floor = 4'd3;
        expect_ev(EV_DOOR, DW + 4, 0);
        send(3);
        wait_door(1'b1, 5, "s5_door_open");
        tick(2);
        send(3);
        check("s5_reopen_pending", int'(pending), 0);
        wait_door(1'b0, 30, "s5_door_close");
        check("s5_idle_tv", int'(target_valid), 0);

        // Reset during dwell with 2, 5, 7 pending.
        do_reset();
        current_floor = 4'd0;
        send(0);
        wait_door(1'b1, 5, "s6_door_open");
        send(2);
        send(5);
        send(7);
        check("s6_pending", int'(pending), 'h0A4);
        check("s6_in_door", int'(door_open), 1);
        rst = 1'b1; req_valid = 1'b1; req_floor = 4'd4;
        @(negedge clk);
        check_reset("s6_reset");
        rst = 1'b0; req_valid = 1'b0;
        tick(2);
        check("s6_reset_req_ignored", int'(pending), 0);

        tick(2);
        check("sb_drain", sbq.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/elevator_request_scheduler.md
ELEVATOR_REQUEST_SCHEDULER -- requirements
Module: elevator_request_scheduler

Interface
REQ-001 The block SHALL have parameter NUM_FLOORS, default 10, number of served floors (0..NUM_FLOORS-1, NUM_FLOORS <= 16).
REQ-002 The block SHALL have parameter DWELL_CYCLES, default 8, door-open dwell length in clk cycles (>= 1).
REQ-003 The block SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 The block SHALL have port rst  input  1  synchronous active-high reset.
REQ-005 The block SHALL have port req_valid  input  1  one-cycle request strobe.
REQ-006 The block SHALL have port req_floor  input  4  requested floor, sampled when req_valid=1.
REQ-007 The block SHALL have port current_floor  input  4  floor currently reported by the car.
REQ-008 The block SHALL have port car_moving  input  1  1 while the car is between floors or travelling.
REQ-009 The block SHALL have port target_floor  output  4  registered floor the car is sent to.
REQ-010 The block SHALL have port target_valid  output  1  target_floor holds a pending destination.
REQ-011 The block SHALL have port dir_up  output  1  current sweep direction (1=up, 0=down).
REQ-012 The block SHALL have port door_open  output  1  door dwell in progress.
REQ-013 The block SHALL have port pending  output  NUM_FLOORS  bitmap of outstanding requests.
REQ-014 The block SHALL have port req_err  output  1  one-cycle pulse, request rejected (floor >= NUM_FLOORS).

Function
REQ-015 States SHALL be IDLE, SWEEP_UP, SWEEP_DOWN, DOOR; encoding implementation-defined.
REQ-016 Accepted request SHALL set pending[req_floor] on the next rising edge; duplicate requests SHALL be idempotent.
REQ-017 req_floor >= NUM_FLOORS SHALL leave pending unchanged and assert req_err for exactly the following cycle.
REQ-018 Arrival = car_moving=0 and pending[current_floor]=1 in IDLE/SWEEP_UP/SWEEP_DOWN; on arrival the block SHALL clear pending[current_floor], enter DOOR, load dwell counter with DWELL_CYCLES.
REQ-019 DOOR SHALL hold door_open=1 for exactly DWELL_CYCLES cycles, then exit per REQ-021..REQ-023 using the pending bitmap at that edge.
REQ-020 A request for current_floor received during DOOR SHALL NOT set pending and SHALL reload the dwell counter to DWELL_CYCLES (door reopen).
REQ-021 SWEEP_UP: target = lowest pending floor > current_floor; if none and any pending below, switch to SWEEP_DOWN, dir_up=0.
REQ-022 SWEEP_DOWN: target = highest pending floor < current_floor; if none and any pending above, switch to SWEEP_UP, dir_up=1.
REQ-023 IDLE (or sweep/DOOR exit with pending empty -> IDLE): on first nonzero pending pick nearest floor by |distance|; tie SHALL go up; enter matching sweep.
REQ-024 target_floor and target_valid SHALL be registered, updating one cycle after the pending/state change that alters them; target_valid=0 in IDLE and DOOR.
REQ-025 A request arriving in the same cycle an arrival clears that same floor SHALL be dropped (clear wins).
REQ-026 Requests for floors other than current_floor SHALL be accepted in every state, including DOOR, with no back-pressure.
REQ-027 dir_up SHALL be retained through DOOR and IDLE until a new sweep selects a direction.
REQ-028 Dwell counter width SHALL be clog2(DWELL_CYCLES+1); no counter SHALL wrap.

Reset
REQ-029 rst=1 at a rising edge SHALL force IDLE, pending=0, target_floor=0, target_valid=0, dir_up=1, door_open=0, req_err=0, dwell counter=0.
REQ-030 Reset mid-operation (any state, including DOOR) SHALL discard all pending requests; requests with req_valid=1 during reset SHALL be ignored.

Verification
REQ-031 Reset, current_floor=0, request floor 3 -> pending=0x008 next cycle, SWEEP_UP, target_floor=3, target_valid=1 one cycle later.
REQ-032 current_floor=0, requests 5 then 2 -> target 2 first; at floor 2 with car_moving=0 door_open=1 for 8 cycles; then target 5.
REQ-033 current_floor=4 sweeping up, pending floors 1 and 6 -> target 6; after floor 6 dwell, SWEEP_DOWN, dir_up=0, target 1.
REQ-034 IDLE at floor 4, requests 2 and 6 same-tie (sequential cycles) -> nearest tie resolves up, target 6.
REQ-035 Request floor 12 -> req_err pulse one cycle, pending unchanged; request current floor during DOOR -> dwell restarts, pending bit stays 0.
REQ-036 rst asserted during DOOR with pending=0x0A4 -> next cycle all outputs at reset values, pending=0.
